// File: rtl/multdiv_pkg.sv
// Shared types and fixed latencies for the multi-cycle multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Latencies in edges after the strobe edge, for the 32-bit configuration
  localparam int MULT_LAT = 17;
  localparam int DIV_LAT  = 33;
  localparam int DIV0_LAT = 1;

  typedef struct packed {
    logic zero;
    logic one;
    logic two;
    logic neg;
  } booth_sel_t;

endpackage

// File: rtl/multdiv_unit_if.sv
// Execute-stage <-> multiply/divide unit handshake and operand/result bus.
interface multdiv_unit_if #(parameter int WIDTH = 32);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_booth_enc.sv
// Radix-4 Booth recoder: 3 overlapping multiplier bits -> partial-product select.
module multdiv_booth_enc
  import multdiv_pkg::*;
(
  input  logic [2:0]  bits,
  output booth_sel_t  sel
);
  assign sel.zero = (bits == 3'b000) || (bits == 3'b111);
  assign sel.two  = (bits == 3'b011) || (bits == 3'b100);
  assign sel.one  = bits[1] ^ bits[0];
  assign sel.neg  = bits[2] & ~(bits[1] & bits[0]);
endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiplier (radix-4 Booth) / divider (non-restoring).
// MULTDIV_EARLY_DIV0_EN: divide by zero completes one edge after the strobe.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MULT_ITERS = WIDTH / 2,
  parameter int DIV_ITERS  = WIDTH
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_unit_if.slave  bus
);
  localparam int CW = $clog2(DIV_ITERS + 1);

  state_e                    state, state_nxt;
  logic [CW-1:0]             cnt;
  logic signed [2*WIDTH-1:0] acc, mcand, pp;
  logic [WIDTH:0]            mplr;
  logic [WIDTH+1:0]          rem, rem_nxt;
  logic [WIDTH-1:0]          quo, dvsr, abs_a, abs_b;
  logic                      q_neg, d_ovf, d_zero;
  logic [WIDTH-1:0]          result;
  logic                      exc, rdy, start, mult_last, div_last;
  logic [WIDTH:0]            prod_hi;
  booth_sel_t                sel;

  assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign mult_last = (cnt == CW'(MULT_ITERS));
`ifdef MULTDIV_EARLY_DIV0_EN
  assign div_last  = (cnt == CW'(DIV_ITERS)) || d_zero;
`else
  assign div_last  = (cnt == CW'(DIV_ITERS));
`endif

  always_comb begin
    state_nxt = state;
    if (bus.ctrl_MULT)     state_nxt = MULT;
    else if (bus.ctrl_DIV) state_nxt = DIV;
    else begin
      case (state)
        MULT:    if (mult_last) state_nxt = DONE;
        DIV:     if (div_last)  state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  multdiv_booth_enc u_enc (.bits(mplr[2:0]), .sel(sel));

  always_comb begin
    pp = '0;
    if (sel.zero)     pp = '0;
    else if (sel.two) pp = mcand <<< 1;
    else if (sel.one) pp = mcand;
    if (sel.neg) pp = -pp;
  end

  // Remainder is kept two bits wider than the magnitudes so 2r +/- d never wraps
  assign rem_nxt = rem[WIDTH+1] ? {rem[WIDTH:0], quo[WIDTH-1]} + {2'b00, dvsr}
                                : {rem[WIDTH:0], quo[WIDTH-1]} - {2'b00, dvsr};
  assign abs_a   = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b   = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  assign prod_hi = acc[2*WIDTH-1:WIDTH-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      q_neg  <= 1'b0;
      d_ovf  <= 1'b0;
      d_zero <= 1'b0;
      result <= '0;
      exc    <= 1'b0;
      rdy    <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy   <= 1'b0;
      if (start) begin
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
        mplr   <= {bus.data_operandB, 1'b0};
        rem    <= '0;
        quo    <= abs_a;
        dvsr   <= abs_b;
        q_neg  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        d_ovf  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.data_operandB);
        d_zero <= (bus.data_operandB == '0);
      end else begin
        case (state)
          MULT: begin
            if (mult_last) begin
              result <= acc[WIDTH-1:0];
              exc    <= !((&prod_hi) || !(|prod_hi));
              rdy    <= 1'b1;
            end else begin
              acc   <= acc + pp;
              mcand <= mcand <<< 2;
              mplr  <= {2'b00, mplr[WIDTH:2]};
              cnt   <= cnt + CW'(1);
            end
          end
          DIV: begin
            if (div_last) begin
              // Min/-1 naturally yields a magnitude of 2^(WIDTH-1) with positive sign
              result <= d_zero ? '0 : (q_neg ? -quo : quo);
              exc    <= d_zero | d_ovf;
              rdy    <= 1'b1;
            end else begin
              rem <= rem_nxt;
              quo <= {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
              cnt <= cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data_result    = result;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = rdy;
  assign bus.busy           = (state == MULT) || (state == DIV);
endmodule
